// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake while idle and
// shifts it out LSB first, each symbol held for CLOCK_FREQ/BAUD_RATE clock cycles.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int unsigned SymbolEdgeTime = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = (SymbolEdgeTime < 2) ? 1 : $clog2(SymbolEdgeTime);
  localparam logic [CntW-1:0] CntMax = CntW'(SymbolEdgeTime - 1);

  // A symbol shorter than two clocks cannot be framed by this counter scheme.
  if (SymbolEdgeTime < 2) begin : gen_bad_cfg
    $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            sym_done;

  assign sym_done      = (cnt_q == CntMax);
  assign data_in_ready = (state_q == StIdle);
  assign serial_out    = tx_q;

  // Next-state logic: the line register changes only on symbol boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (data_in_valid) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = data_in;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (sym_done) begin
          state_d = StData;
          cnt_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (sym_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (sym_done) begin
          state_d = StIdle;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst as in the codebase; polarity and synchronicity are fixed.
REQ-002 Parameter CLOCK_FREQ, default 50_000_000: clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 115200: serial bit rate in bits/s.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Port data_in  input  8  byte to transmit; sampled only on handshake.
REQ-007 Port data_in_valid  input  1  producer offers data_in this cycle.
REQ-008 Port data_in_ready  output  1  transmitter can accept a byte this cycle.
REQ-009 Port serial_out  output  1  UART line, idle high; connects to FPGA_SERIAL_TX.

Function
REQ-010 SYMBOL_EDGE_TIME SHALL be CLOCK_FREQ/BAUD_RATE, truncating integer division (434 at defaults); counters SHALL be sized by clog2 of this value.
REQ-011 Configurations with SYMBOL_EDGE_TIME < 2 are unsupported and SHALL be rejected at elaboration.
REQ-012 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), no parity.
REQ-013 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-014 data_in_ready SHALL be 1 iff state is IDLE, decoded combinationally from the state register.
REQ-015 A handshake SHALL occur on a rising edge where data_in_valid and data_in_ready are both 1; data_in SHALL be captured into an internal shift register at that edge.
REQ-016 At the handshake edge t0, state SHALL go to START and serial_out, a register, SHALL go to 0.
REQ-017 Each bit SHALL be held for exactly SYMBOL_EDGE_TIME cycles: start bit from edge t0, data bit i (i=0..7) from edge t0+(i+1)*S, stop bit from edge t0+9*S, with S = SYMBOL_EDGE_TIME.
REQ-018 At edge t0+10*S, state SHALL return to IDLE and serial_out SHALL remain 1, giving a frame of exactly 10*S cycles.
REQ-019 A 3-bit bit counter SHALL count data bits in DATA; DATA SHALL exit to STOP after bit 7 completes its full symbol time.
REQ-020 The cycle counter SHALL reset to 0 on every bit transition and on handshake; it SHALL not free-run in IDLE.
REQ-021 data_in_valid asserted outside IDLE SHALL be ignored; there is no queue, and changes on data_in after the handshake SHALL not affect the frame in flight.
REQ-022 Back-to-back frames: a byte offered with valid held high SHALL be accepted at edge t0+10*S+1 (first IDLE cycle), giving at least 1 clock of idle-high between the stop bit and the next start bit.
REQ-023 In IDLE with no handshake, serial_out SHALL stay 1 and all counters SHALL hold.

Reset
REQ-024 While rst=0, with immediate asynchronous effect, state SHALL be IDLE, serial_out 1, data_in_ready 1, counters and shift register 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (serial_out 1 with no further bits); after reset release, the first handshake SHALL start a complete new frame.
REQ-026 No handshake SHALL be accepted while rst=0.

Verification (use CLOCK_FREQ=8, BAUD_RATE=1, so S=8, unless stated)
REQ-027 Reset: assert rst=0 for 3 cycles then release -> serial_out=1, data_in_ready=1, and serial_out stays 1 for 20 idle cycles.
REQ-028 Single byte 0xA5, valid for 1 cycle -> ready=0 after t0; line reads 0,1,0,1,0,0,1,0,1,1, each held exactly 8 cycles; ready=1 at t0+80.
REQ-029 Back-to-back 0x00 then 0xFF, valid held high -> second handshake at t0+81; line is 0 for 72 cycles, then 1 for 9, then 0 for 8, then 1 for 72.
REQ-030 Busy-ignore: during the 0x3C frame, pulse valid with data_in=0xFF at t0+20 -> the 0x3C waveform is unchanged, with no extra frame.
REQ-031 Mid-frame reset: send 0x55, assert rst=0 at t0+35 -> serial_out=1 in the same cycle with no clock edge needed; after release, 0x81 is sent as a complete correct frame.
REQ-032 Default parameters: send 0x41 -> each bit lasts 434 cycles and the frame lasts 4340 cycles; a UART receiver model at 115200 decodes 0x41.
